// File: rtl/conf_int_add_err_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conf_int_add_err_pkg
// Brief    : Shared types, default widths and saturating-add helper for the
//            approximate-adder error monitor.
// Revision : 1.0 - initial release
// ============================================================================
package conf_int_add_err_pkg;

    localparam int c_DEF_OP_BITWIDTH = 32;
    localparam int c_DEF_NUM_SAMPLES = 500;
    localparam int c_DEF_CNT_W       = 16;
    localparam int c_DEF_ACC_W       = 48;
    // Widest accumulator the saturating-add helper supports
    localparam int c_SAT_MAX_W       = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Returns {saturated, result}; operands must already fit in 'width' bits.
    function automatic logic [c_SAT_MAX_W:0] sat_add(
        input logic [c_SAT_MAX_W-1:0] acc,
        input logic [c_SAT_MAX_W-1:0] inc,
        input int unsigned            width
    );
        logic [c_SAT_MAX_W:0]   sum;
        logic [c_SAT_MAX_W-1:0] mask;
        logic                   carry;
        mask  = ~({c_SAT_MAX_W{1'b1}} << width);
        sum   = {1'b0, acc} + {1'b0, inc};
        carry = |(sum >> width);
        if (carry) begin
            return {1'b1, mask};
        end
        return {1'b0, sum[c_SAT_MAX_W-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/conf_int_add_err_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : conf_int_add_err_monitor_if
// Brief    : Sample stream and statistics bundle of the error monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface conf_int_add_err_monitor_if
    import conf_int_add_err_pkg::*;
#(
    parameter int OP_BITWIDTH = c_DEF_OP_BITWIDTH,
    parameter int CNT_W       = c_DEF_CNT_W,
    parameter int ACC_W       = c_DEF_ACC_W
);

    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_BITWIDTH-1:0] a;
    logic [OP_BITWIDTH-1:0] b;
    logic [OP_BITWIDTH-1:0] d;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       sample_cnt;
    logic [CNT_W-1:0]       mismatch_cnt;
    logic [OP_BITWIDTH:0]   max_abs_err;
    logic [ACC_W-1:0]       sum_abs_err;
    logic                   sum_sat;

    modport master (
        output start, in_valid, a, b, d,
        input  in_ready, busy, done, sample_cnt, mismatch_cnt,
               max_abs_err, sum_abs_err, sum_sat
    );

    modport slave (
        input  start, in_valid, a, b, d,
        output in_ready, busy, done, sample_cnt, mismatch_cnt,
               max_abs_err, sum_abs_err, sum_sat
    );

endinterface
`default_nettype wire

// File: rtl/conf_int_add_err_monitor_stage.sv
`default_nettype none
// ============================================================================
// Module   : conf_int_add_err_stage
// Brief    : Two-stage pipeline: exact sum and signed error, then |error|.
// Revision : 1.0 - initial release
// ============================================================================
module conf_int_add_err_stage
    import conf_int_add_err_pkg::*;
#(
    parameter int OP_BITWIDTH = c_DEF_OP_BITWIDTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_valid,
    input  wire logic [OP_BITWIDTH-1:0] i_a,
    input  wire logic [OP_BITWIDTH-1:0] i_b,
    input  wire logic [OP_BITWIDTH-1:0] i_d,
    output logic                        o_s1_valid,
    output logic                        o_valid,
    output logic [OP_BITWIDTH:0]        o_abs_err
);

    localparam int c_EW = OP_BITWIDTH + 1;

    logic [OP_BITWIDTH-1:0] w_exact;
    logic signed [c_EW-1:0] w_err;
    logic                   r_v1;
    logic signed [c_EW-1:0] r_err;
    logic                   r_v2;
    logic [c_EW-1:0]        r_abs;

    // One extra bit keeps d - exact exact for any pair of OP_BITWIDTH values
    assign w_exact = i_a + i_b;
    assign w_err   = $signed({i_d[OP_BITWIDTH-1], i_d})
                   - $signed({w_exact[OP_BITWIDTH-1], w_exact});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_err <= '0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_err <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_abs <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_abs <= r_err[c_EW-1] ? $unsigned(-r_err) : $unsigned(r_err);
            end
        end
    end

    assign o_s1_valid = r_v1;
    assign o_valid    = r_v2;
    assign o_abs_err  = r_abs;

endmodule
`default_nettype wire

// File: rtl/conf_int_add_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : conf_int_add_err_monitor
// Brief    : Windowed error statistics for an approximate integer adder.
// Revision : 1.0 - initial release
// ============================================================================
module conf_int_add_err_monitor
    import conf_int_add_err_pkg::*;
#(
    parameter int OP_BITWIDTH = c_DEF_OP_BITWIDTH,
    parameter int NUM_SAMPLES = c_DEF_NUM_SAMPLES,
    parameter int CNT_W       = c_DEF_CNT_W,
    parameter int ACC_W       = c_DEF_ACC_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    conf_int_add_err_monitor_if.slave  bus
);

    generate
        if (NUM_SAMPLES < 1 || (NUM_SAMPLES >> CNT_W) != 0) begin : g_chk_samples
            $error("NUM_SAMPLES must be in [1, 2**CNT_W)");
        end
        if (ACC_W < OP_BITWIDTH + 1 || ACC_W >= c_SAT_MAX_W) begin : g_chk_acc
            $error("ACC_W must be in [OP_BITWIDTH+1, c_SAT_MAX_W)");
        end
    endgenerate

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   w_in_ready;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_clear;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_s1_valid;
    logic                   w_s2_valid;
    logic [OP_BITWIDTH:0]   w_abs;
    logic [c_SAT_MAX_W:0]   w_sat_res;
    logic                   w_unused_sat;

    logic [CNT_W-1:0]       r_accept_cnt;
    logic [CNT_W-1:0]       r_sample_cnt;
    logic [CNT_W-1:0]       r_mismatch_cnt;
    logic [OP_BITWIDTH:0]   r_max_abs;
    logic [ACC_W-1:0]       r_sum;
    logic                   r_sum_sat;

    conf_int_add_err_stage #(
        .OP_BITWIDTH (OP_BITWIDTH)
    ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_accept),
        .i_a        (bus.a),
        .i_b        (bus.b),
        .i_d        (bus.d),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_s2_valid),
        .o_abs_err  (w_abs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && w_last) w_state_nxt = ST_DRAIN;
            // Stage 1 empty means stage 2 retires its last sample on this edge,
            // so the final stats and done appear together.
            ST_DRAIN: if (!w_s1_valid) w_state_nxt = ST_DONE;
            ST_DONE:  if (bus.start) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            ST_IDLE:  w_clear = bus.start;
            ST_RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            ST_DRAIN: w_busy = 1'b1;
            ST_DONE: begin
                w_done  = 1'b1;
                w_clear = bus.start;
            end
            default: ;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = (r_accept_cnt == CNT_W'(NUM_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_accept_cnt <= '0;
        end else if (w_accept) begin
            r_accept_cnt <= r_accept_cnt + 1'b1;
        end
    end

    assign w_sat_res    = sat_add(c_SAT_MAX_W'(r_sum), c_SAT_MAX_W'(w_abs), ACC_W);
    assign w_unused_sat = ^w_sat_res[c_SAT_MAX_W-1:ACC_W];

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_sample_cnt   <= '0;
            r_mismatch_cnt <= '0;
            r_max_abs      <= '0;
            r_sum          <= '0;
            r_sum_sat      <= 1'b0;
        end else if (w_s2_valid) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
            if (w_abs != '0) begin
                r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end
            if (w_abs > r_max_abs) begin
                r_max_abs <= w_abs;
            end
            r_sum <= w_sat_res[ACC_W-1:0];
            if (w_sat_res[c_SAT_MAX_W]) begin
                r_sum_sat <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.sample_cnt   = r_sample_cnt;
    assign bus.mismatch_cnt = r_mismatch_cnt;
    assign bus.max_abs_err  = r_max_abs;
    assign bus.sum_abs_err  = r_sum;
    assign bus.sum_sat      = r_sum_sat;

endmodule
`default_nettype wire

// File: tb/tb_conf_int_add_err_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_conf_int_add_err_monitor
// Brief    : Randomised self-checking bench with a windowed statistics model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conf_int_add_err_monitor;

    localparam int     OPW     = 32;
    localparam int     NS      = 4;
    localparam int     CW      = 16;
    localparam int     AW      = 33;
    localparam longint SAT_MAX = (64'sd1 <<< AW) - 64'sd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conf_int_add_err_monitor_if #(.OP_BITWIDTH(OPW), .CNT_W(CW), .ACC_W(AW)) mon_if ();

    conf_int_add_err_monitor #(
        .OP_BITWIDTH (OPW),
        .NUM_SAMPLES (NS),
        .CNT_W       (CW),
        .ACC_W       (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mon_if.slave)
    );

    int     n_checks = 0;
    int     n_fails  = 0;
    longint m_cnt, m_mis, m_max, m_sum;
    bit     m_sat;
    int     accepted;
    int     f1, f2;
    longint sc_exp;
    bit     hs_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_mis = 0; m_max = 0; m_sum = 0; m_sat = 1'b0;
        accepted = 0; f1 = 0; f2 = 0; sc_exp = 0;
    endtask

    // Reference: exact sum modulo 2^OPW, signed error, saturating total.
    task automatic model_push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        logic [31:0] ex;
        longint      err;
        longint      ab;
        ex  = a + b;
        err = longint'($signed(d)) - longint'($signed(ex));
        ab  = (err < 0) ? -err : err;
        m_cnt++;
        if (ab != 0) m_mis++;
        if (ab > m_max) m_max = ab;
        m_sum = m_sum + ab;
        if (m_sum > SAT_MAX) begin
            m_sum = SAT_MAX;
            m_sat = 1'b1;
        end
    endtask

    // A sample accepted at edge j shows up in sample_cnt after edge j+2.
    task automatic step(input int fire);
        @(posedge clk);
        sc_exp = sc_exp + f2;
        f2 = f1;
        f1 = fire;
        @(negedge clk);
    endtask

    task automatic gen(input int mode, input int idx,
                       output logic [31:0] a, output logic [31:0] b, output logic [31:0] d);
        logic [31:0] ta [4] = '{32'd1, 32'hFFFF_FFFB, 32'd0, 32'd100};
        logic [31:0] tb [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] td [4] = '{32'd3, 32'd2, 32'd0, 32'd99};
        logic [31:0] eo [4] = '{32'd3, 32'hFFFF_FFF6, 32'd0, 32'd0};
        logic [31:0] ex;
        a  = $urandom;
        b  = $urandom;
        ex = a + b;
        case (mode)
            0: begin a = ta[idx]; b = tb[idx]; d = td[idx]; end
            1: d = ex + eo[idx];
            2: begin
                a = 32'h7FFF_FFFF;
                b = 32'd1;
                d = (idx == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            3: d = ex + 32'($urandom_range(0, 40)) - 32'd20;
            4: d = $urandom;
            default: d = ex;
        endcase
    endtask

    task automatic check_final();
        check("sample_cnt",   64'(mon_if.sample_cnt),   64'(m_cnt));
        check("mismatch_cnt", 64'(mon_if.mismatch_cnt), 64'(m_mis));
        check("max_abs_err",  64'(mon_if.max_abs_err),  64'(m_max));
        check("sum_abs_err",  64'(mon_if.sum_abs_err),  64'(m_sum));
        check("sum_sat",      64'(mon_if.sum_sat),      64'(m_sat));
    endtask

    // vpct < 0 selects the fixed 1,0,1,1 valid pattern.
    task automatic run_window(input int mode, input int vpct);
        logic [31:0] a, b, d;
        int          fire;
        int          cyc;
        model_clear();
        mon_if.start    = 1'b1;
        mon_if.in_valid = 1'b0;
        step(0);
        mon_if.start = 1'b0;
        check("run_ready",   64'(mon_if.in_ready),    64'd1);
        check("run_busy",    64'(mon_if.busy),        64'd1);
        check("clear_cnt",   64'(mon_if.sample_cnt),  64'd0);
        check("clear_sum",   64'(mon_if.sum_abs_err), 64'd0);
        check("clear_sat",   64'(mon_if.sum_sat),     64'd0);
        cyc = 0;
        while (accepted < NS && cyc < 200) begin
            gen(mode, accepted, a, b, d);
            mon_if.a = a;
            mon_if.b = b;
            mon_if.d = d;
            mon_if.in_valid = (vpct < 0) ? hs_pat[cyc % 4] : ($urandom_range(0, 99) < vpct);
            mon_if.start    = ($urandom_range(0, 5) == 0);
            fire = (mon_if.in_valid && mon_if.in_ready) ? 1 : 0;
            if (fire != 0) begin
                model_push(a, b, d);
                accepted++;
            end
            step(fire);
            check("lag_cnt", 64'(mon_if.sample_cnt), 64'(sc_exp));
            cyc++;
        end
        if (accepted < NS) check("accept_budget", 64'(accepted), 64'(NS));
        mon_if.start    = 1'b0;
        mon_if.in_valid = 1'b1;
        mon_if.a        = $urandom;
        mon_if.d        = $urandom;
        check("drain_ready", 64'(mon_if.in_ready), 64'd0);
        check("drain_busy",  64'(mon_if.busy),     64'd1);
        check("drain_done",  64'(mon_if.done),     64'd0);
        step(0);
        check("done_k1",     64'(mon_if.done),     64'd0);
        step(0);
        check("done_k2",     64'(mon_if.done),     64'd1);
        check("done_busy",   64'(mon_if.busy),     64'd0);
        check("done_ready",  64'(mon_if.in_ready), 64'd0);
        check_final();
        step(0);
        check("frozen_cnt",  64'(mon_if.sample_cnt),  64'(m_cnt));
        check("frozen_sum",  64'(mon_if.sum_abs_err), 64'(m_sum));
        mon_if.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(mon_if.in_ready),     64'd0);
        check({tag, "_busy"},  64'(mon_if.busy),         64'd0);
        check({tag, "_done"},  64'(mon_if.done),         64'd0);
        check({tag, "_cnt"},   64'(mon_if.sample_cnt),   64'd0);
        check({tag, "_mis"},   64'(mon_if.mismatch_cnt), 64'd0);
        check({tag, "_max"},   64'(mon_if.max_abs_err),  64'd0);
        check({tag, "_sum"},   64'(mon_if.sum_abs_err),  64'd0);
        check({tag, "_sat"},   64'(mon_if.sum_sat),      64'd0);
    endtask

    initial begin
        mon_if.start    = 1'b0;
        mon_if.in_valid = 1'b0;
        mon_if.a        = '0;
        mon_if.b        = '0;
        mon_if.d        = '0;
        model_clear();
        rst = 1'b1;
        step(0);
        step(0);
        rst = 1'b0;
        check_all_zero("reset");

        run_window(0, 100);
        check("exact_mis", 64'(mon_if.mismatch_cnt), 64'd0);
        check("exact_cnt", 64'(mon_if.sample_cnt),   64'd4);

        run_window(1, 100);
        check("err_mis", 64'(mon_if.mismatch_cnt), 64'd2);
        check("err_max", 64'(mon_if.max_abs_err),  64'd10);
        check("err_sum", 64'(mon_if.sum_abs_err),  64'd13);

        run_window(2, 100);
        check("wrap_max", 64'(mon_if.max_abs_err), 64'hFFFF_FFFF);
        check("sat_sum",  64'(mon_if.sum_abs_err), 64'h1_FFFF_FFFF);
        check("sat_flag", 64'(mon_if.sum_sat),     64'd1);

        run_window(5, -1);

        // Reset after two accepted samples discards the in-flight window.
        model_clear();
        mon_if.start = 1'b1;
        step(0);
        mon_if.start    = 1'b0;
        mon_if.in_valid = 1'b1;
        mon_if.d        = $urandom;
        step(1);
        step(1);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        mon_if.in_valid = 1'b0;
        check_all_zero("midrst");
        step(0);
        step(0);
        check_all_zero("midrst_flush");

        for (int w = 0; w < 12; w++) begin
            run_window(3 + (w % 3), 30 + int'($urandom_range(0, 70)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/conf_int_add_err_monitor.md
# conf_int_add_err_monitor

Synthesizable error monitor that sits at the output end of the configurable approximate integer adder. It receives each operand pair and the adder's result, recomputes the exact sum, and accumulates error statistics over a fixed window of samples: sample count, mismatch count, maximum absolute error and saturating sum of absolute errors. This replaces off-line result-file comparison with on-chip, cycle-accurate characterisation.

## Interface
- OP_BITWIDTH, 32, operand/result width of the monitored adder
- NUM_SAMPLES, 500, window length in accepted samples (≥1, < 2^CNT_W)
- CNT_W, 16, width of sample/mismatch counters
- ACC_W, 48, width of absolute-error accumulator (≥ OP_BITWIDTH+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear stats, open window
- in_valid  in  1  a/b/d valid this cycle
- in_ready  out  1  monitor accepts a sample this cycle
- a  in  OP_BITWIDTH  operand a (two's complement)
- b  in  OP_BITWIDTH  operand b
- d  in  OP_BITWIDTH  approximate sum from adder
- busy  out  1  window open or pipeline draining
- done  out  1  window complete; stats final
- sample_cnt  out  CNT_W  samples accumulated
- mismatch_cnt  out  CNT_W  samples with d ≠ exact
- max_abs_err  out  OP_BITWIDTH+1  largest |d − exact|
- sum_abs_err  out  ACC_W  Σ|d − exact|, saturating
- sum_sat  out  1  sticky: sum_abs_err saturated

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: outputs hold last values; in_ready=0. start → clear all stats and sum_sat, go RUN.
- RUN: in_ready=1. Accept = in_valid & in_ready. Upon the NUM_SAMPLES-th accept, go DRAIN (in_ready=0 from next cycle).
- DRAIN: in_ready=0; wait for both pipeline stages to empty, then go DONE.
- DONE: done=1, stats frozen. start → clear and go RUN (same as from IDLE).
- start during RUN or DRAIN: ignored.
- Stage 1 on accept: exact = (a+b) mod 2^OP_BITWIDTH. err = sign-extended d − sign-extended exact, computed in OP_BITWIDTH+1 bits signed.
- Stage 2: abs = |err| in OP_BITWIDTH+1 bits unsigned (fits, no overflow).
- Updates:
  - sample_cnt += 1
  - mismatch_cnt += (abs≠0)
  - max_abs_err = max(max_abs_err, abs)
  - sum_abs_err += abs; on carry-out, saturate to all-ones and set sum_sat.
- Counters do not wrap: NUM_SAMPLES < 2^CNT_W is enforced by elaboration-time check.
- busy = state ∈ {RUN, DRAIN}.

## Timing
- Reset: state=IDLE, in_ready=0, busy=0, done=0, all stats 0, sum_sat=0, pipeline valids 0.
- Latency: a sample accepted at edge k is reflected in the stats outputs after edge k+2.
- The last accept occurs at edge k. From edge k+1 the state is DRAIN. At edge k+2 the final stats and done=1 become visible together.
- in_ready is combinational from state only. It does not depend on in_valid.
- Throughput: one sample per cycle, no bubbles.
- rst mid-window: full return to reset values at that edge; in-flight samples are discarded.
- start coincident with rst: rst wins.

## Structure
- Package conf_int_add_err_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default width constants
  - function for saturating add.
- Sub-module conf_int_add_err_stage: the two-stage exact-sum/abs-error pipeline, with valid passthrough.
- The top level holds the FSM and accumulators.

## Test plan
- Exact adder, NUM_SAMPLES=4, pairs (1,2,3), (−5,7,2), (0,0,0), (100,−1,99) → done after 4 accepts+2 cycles; mismatch_cnt=0, max_abs_err=0, sum_abs_err=0, sample_cnt=4.
- Errors: d = exact+3, then exact−10, then exact → mismatch_cnt=2, max_abs_err=10, sum_abs_err=13.
- Wrap-around: a=0x7FFFFFFF, b=1, d=0x80000000 → abs=0. Same pair with d=0x7FFFFFFF → abs=0x1_0000_0001? No: err=0x7FFFFFFF−(−2^31)=2^32−1, so abs=0xFFFFFFFF.
- Saturation: ACC_W=33, repeated abs=0xFFFFFFFF → sum_abs_err=0x1_FFFF_FFFF, sum_sat=1, held through DONE.
- Handshake: in_valid toggling 1,0,1,1 with NUM_SAMPLES=3 → exactly 3 accepts; in_ready=0 the cycle after the 3rd accept; extra valid samples ignored; start mid-RUN ignored.
- Reset mid-window after 2 samples → all outputs 0, IDLE. A new start runs a clean window.
